// File: rtl/resource_pool_arbiter_pkg.sv
// Shared types and helpers for the resource pool arbiter.
// Holds the port-state enum and the wrap-aware issue-ID age comparison.
package resource_pool_arbiter_pkg;

    typedef enum logic [1:0] {
        PORT_IDLE = 2'd0,
        PORT_WAIT = 2'd1,
        PORT_HOLD = 2'd2
    } port_state_e;

    localparam int ID_MAX_W = 64;

    // a is older than b when (a - b) mod 2^id_w has its top bit set.
    function automatic logic id_older(input logic [ID_MAX_W-1:0] a,
                                      input logic [ID_MAX_W-1:0] b,
                                      input int unsigned         id_w);
        logic [ID_MAX_W-1:0] diff;
        diff = a - b;
        return diff[id_w-1];
    endfunction

endpackage

// File: rtl/resource_pool_arbiter_priority_picker.sv
// Ranks waiting ports and selects the top free_cnt of them (combinational).
// RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN selects issue-ID age ranking; otherwise round-robin.
module resource_pool_arbiter_priority_picker
    import resource_pool_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int ID_WIDTH  = 16,
    parameter int FREE_W    = 4,
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0]          wait_mask,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
    input  logic [PORT_W-1:0]             rr_ptr,
    input  logic [FREE_W-1:0]             free_cnt,
    output logic [NUM_PORTS-1:0]          pick_mask,
    output logic [NUM_PORTS*PORT_W-1:0]   pick_rank
);

`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
    function automatic logic beats(input int q, input int p);
        logic [ID_WIDTH-1:0] idq;
        logic [ID_WIDTH-1:0] idp;
        idq = req_id[q*ID_WIDTH +: ID_WIDTH];
        idp = req_id[p*ID_WIDTH +: ID_WIDTH];
        if (idq == idp) return q < p;
        return id_older(ID_MAX_W'(idq), ID_MAX_W'(idp), ID_WIDTH);
    endfunction

    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;
`else
    // Distance from the pointer port decides order; distances are unique.
    function automatic logic beats(input int q, input int p);
        int dq;
        int dp;
        dq = (q - int'(rr_ptr) + NUM_PORTS) % NUM_PORTS;
        dp = (p - int'(rr_ptr) + NUM_PORTS) % NUM_PORTS;
        return dq < dp;
    endfunction

    logic unused_id;
    assign unused_id = ^req_id;
`endif

    // A port's rank is the number of waiting ports that beat it.
    always_comb begin
        int rank;
        rank      = 0;
        pick_mask = '0;
        pick_rank = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rank = 0;
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && wait_mask[q] && beats(q, p)) rank = rank + 1;
            end
            if (wait_mask[p] && rank < int'(free_cnt)) begin
                pick_mask[p]                     = 1'b1;
                pick_rank[p*PORT_W +: PORT_W]    = PORT_W'(rank);
            end
        end
    end

endmodule

// File: rtl/resource_pool_arbiter.sv
// Shared unit pool allocator: grants free units to waiting ports, holds locks until release, clears on flush.
// Optional build macro: RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN (age ranking instead of round-robin).
module resource_pool_arbiter
    import resource_pool_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int NUM_UNITS = 8,
    parameter int ID_WIDTH  = 16,
    parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int FREE_W   = $clog2(NUM_UNITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS*ID_WIDTH-1:0] req_id,
    input  logic                          flush,
    output logic [NUM_PORTS-1:0]          grant,
    output logic [NUM_PORTS*UNIT_W-1:0]   grant_unit,
    output logic [NUM_UNITS-1:0]          unit_busy,
    output logic [NUM_UNITS*PORT_W-1:0]   unit_owner,
    output logic [31:0]                   stall_count
);

    port_state_e                   port_state [NUM_PORTS];
    logic [NUM_PORTS-1:0]          wait_mask;
    logic [NUM_PORTS-1:0]          pick_mask;
    logic [NUM_PORTS*PORT_W-1:0]   pick_rank;
    logic [FREE_W-1:0]             free_cnt;
    logic [NUM_UNITS*UNIT_W-1:0]   free_slot;
    logic [PORT_W-1:0]             rr_ptr;
    logic [PORT_W-1:0]             rr_ptr_d;

    logic [NUM_PORTS-1:0]          grant_d;
    logic [NUM_PORTS*UNIT_W-1:0]   grant_unit_d;
    logic [NUM_UNITS-1:0]          unit_busy_d;
    logic [NUM_UNITS*PORT_W-1:0]   unit_owner_d;
    logic [31:0]                   stall_count_d;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p])    port_state[p] = PORT_HOLD;
            else if (req[p]) port_state[p] = PORT_WAIT;
            else             port_state[p] = PORT_IDLE;
            wait_mask[p] = (port_state[p] == PORT_WAIT);
        end
    end

    // Only units free at the start of the cycle are offered; slot k holds the k-th lowest free unit.
    always_comb begin
        free_cnt  = '0;
        free_slot = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (!unit_busy[u]) begin
                free_slot[int'(free_cnt)*UNIT_W +: UNIT_W] = UNIT_W'(u);
                free_cnt = free_cnt + FREE_W'(1);
            end
        end
    end

    resource_pool_arbiter_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH),
        .FREE_W    (FREE_W)
    ) u_picker (
        .wait_mask (wait_mask),
        .req_id    (req_id),
        .rr_ptr    (rr_ptr),
        .free_cnt  (free_cnt),
        .pick_mask (pick_mask),
        .pick_rank (pick_rank)
    );

    always_comb begin
        logic [PORT_W-1:0] rank;
        logic [UNIT_W-1:0] unit;
        rank          = '0;
        unit          = '0;
        grant_d       = grant;
        grant_unit_d  = grant_unit;
        unit_busy_d   = unit_busy;
        unit_owner_d  = unit_owner;
        stall_count_d = stall_count;
        if (flush) begin
            grant_d      = '0;
            grant_unit_d = '0;
            unit_busy_d  = '0;
            unit_owner_d = '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_state[p] == PORT_HOLD && !req[p]) begin
                    unit = grant_unit[p*UNIT_W +: UNIT_W];
                    unit_busy_d[unit]                        = 1'b0;
                    unit_owner_d[int'(unit)*PORT_W +: PORT_W] = '0;
                    grant_d[p]                               = 1'b0;
                    grant_unit_d[p*UNIT_W +: UNIT_W]         = '0;
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (pick_mask[p]) begin
                    rank = pick_rank[p*PORT_W +: PORT_W];
                    unit = free_slot[int'(rank)*UNIT_W +: UNIT_W];
                    grant_d[p]                               = 1'b1;
                    grant_unit_d[p*UNIT_W +: UNIT_W]         = unit;
                    unit_busy_d[unit]                        = 1'b1;
                    unit_owner_d[int'(unit)*PORT_W +: PORT_W] = PORT_W'(p);
                end
            end
            if (|(wait_mask & ~pick_mask)) stall_count_d = stall_count + 32'd1;
        end
    end

`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
    assign rr_ptr_d = '0;
`else
    // The lowest-priority granted port has the highest rank; the pointer moves just past it.
    always_comb begin
        logic [PORT_W-1:0] best_rank;
        int                last_port;
        best_rank = '0;
        last_port = 0;
        rr_ptr_d  = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick_mask[p] && pick_rank[p*PORT_W +: PORT_W] >= best_rank) begin
                best_rank = pick_rank[p*PORT_W +: PORT_W];
                last_port = p;
            end
        end
        if (!flush && |pick_mask) rr_ptr_d = PORT_W'((last_port + 1) % NUM_PORTS);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            grant_unit  <= '0;
            unit_busy   <= '0;
            unit_owner  <= '0;
            stall_count <= '0;
            rr_ptr      <= '0;
        end else begin
            grant       <= grant_d;
            grant_unit  <= grant_unit_d;
            unit_busy   <= unit_busy_d;
            unit_owner  <= unit_owner_d;
            stall_count <= stall_count_d;
            rr_ptr      <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_resource_pool_arbiter.sv
// Directed bench for resource_pool_arbiter with a reference-model scoreboard.
// Works with or without RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN defined.
module tb_resource_pool_arbiter;

    localparam int N   = 8;
    localparam int U   = 4;
    localparam int IDW = 16;
    localparam int UW  = 2;
    localparam int PW  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*IDW-1:0] req_id = '0;
    logic             flush = 1'b0;
    logic [N-1:0]     grant;
    logic [N*UW-1:0]  grant_unit;
    logic [U-1:0]     unit_busy;
    logic [U*PW-1:0]  unit_owner;
    logic [31:0]      stall_count;

    resource_pool_arbiter #(
        .NUM_PORTS (N),
        .NUM_UNITS (U),
        .ID_WIDTH  (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_id      (req_id),
        .flush       (flush),
        .grant       (grant),
        .grant_unit  (grant_unit),
        .unit_busy   (unit_busy),
        .unit_owner  (unit_owner),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    grant;
        logic [N*UW-1:0] gu;
        logic [U-1:0]    busy;
        logic [U*PW-1:0] owner;
        logic [31:0]     stall;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [N-1:0] m_grant = '0;
    int           m_unit [N];
    logic [U-1:0] m_busy = '0;
    int           m_owner [U];
    logic [31:0]  m_stall = '0;
    int           m_ptr = 0;

    function automatic logic m_older(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
        logic [IDW-1:0] d;
        d = a - b;
        return d[IDW-1];
    endfunction

    function automatic logic m_better(input int a, input int b);
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
        logic [IDW-1:0] ia;
        logic [IDW-1:0] ib;
        ia = req_id[a*IDW +: IDW];
        ib = req_id[b*IDW +: IDW];
        if (ia == ib) return a < b;
        return m_older(ia, ib);
`else
        return ((a - m_ptr + N) % N) < ((b - m_ptr + N) % N);
`endif
    endfunction

    function automatic void m_step();
        logic [U-1:0] freeu;
        logic [N-1:0] rem;
        int           best;
        int           fu;
        int           last;
        if (rst) begin
            m_grant = '0;
            m_busy  = '0;
            m_stall = '0;
            m_ptr   = 0;
        end else if (flush) begin
            m_grant = '0;
            m_busy  = '0;
        end else begin
            freeu = ~m_busy;
            rem   = req & ~m_grant;
            last  = -1;
            for (int p = 0; p < N; p++) begin
                if (m_grant[p] && !req[p]) begin
                    m_busy[m_unit[p]] = 1'b0;
                    m_grant[p]        = 1'b0;
                end
            end
            for (int k = 0; k < N; k++) begin
                fu = -1;
                for (int u = U - 1; u >= 0; u--) if (freeu[u]) fu = u;
                best = -1;
                for (int p = 0; p < N; p++) begin
                    if (rem[p] && (best < 0 || m_better(p, best))) best = p;
                end
                if (fu >= 0 && best >= 0) begin
                    m_grant[best] = 1'b1;
                    m_unit[best]  = fu;
                    m_busy[fu]    = 1'b1;
                    m_owner[fu]   = best;
                    rem[best]     = 1'b0;
                    freeu[fu]     = 1'b0;
                    last          = best;
                end
            end
            if (rem != '0) m_stall = m_stall + 32'd1;
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
            m_ptr = 0;
`else
            if (last >= 0) m_ptr = (last + 1) % N;
`endif
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e.grant = m_grant;
        e.gu    = '0;
        e.busy  = m_busy;
        e.owner = '0;
        e.stall = m_stall;
        for (int p = 0; p < N; p++) if (m_grant[p]) e.gu[p*UW +: UW] = UW'(m_unit[p]);
        for (int u = 0; u < U; u++) if (m_busy[u]) e.owner[u*PW +: PW] = PW'(m_owner[u]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input int p, input logic [IDW-1:0] v);
        req_id[p*IDW +: IDW] = v;
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq, input logic fl);
        exp_t            e;
        logic [N*UW-1:0] gm;
        logic [U*PW-1:0] om;
        rst   = r;
        req   = rq;
        flush = fl;
        m_step();
        sb.push_back(m_expect());
        @(posedge clk);
        #1;
        e  = sb.pop_front();
        gm = '0;
        om = '0;
        for (int p = 0; p < N; p++) if (e.grant[p]) gm[p*UW +: UW] = '1;
        for (int u = 0; u < U; u++) if (e.busy[u]) om[u*PW +: PW] = '1;
        check("grant",       64'(grant),              64'(e.grant));
        check("grant_unit",  64'(grant_unit & gm),    64'(e.gu));
        check("unit_busy",   64'(unit_busy),          64'(e.busy));
        check("unit_owner",  64'(unit_owner & om),    64'(e.owner));
        check("stall_count", 64'(stall_count),        64'(e.stall));
    endtask

    initial begin
        int order [16];
        int n_order;
        n_order = 0;
        for (int i = 0; i < 16; i++) order[i] = -1;

        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("reset_grant", 64'(grant), 64'(0));
        check("reset_stall", 64'(stall_count), 64'(0));

        set_id(3, 16'd5);
        step(1'b0, 8'h08, 1'b0);
        check("first_grant_p3", 64'(grant[3]), 64'(1));
        check("first_unit_p3", 64'(grant_unit[7:6]), 64'(0));
        check("first_busy", 64'(unit_busy), 64'(4'b0001));
        step(1'b0, 8'h00, 1'b0);

        // Ports 6/7 take units 0/1 so only two units remain for ports 0/1/2.
        set_id(6, 16'd100);
        set_id(7, 16'd101);
        step(1'b0, 8'hC0, 1'b0);
        set_id(0, 16'd10);
        set_id(1, 16'd4);
        set_id(2, 16'd7);
        step(1'b0, 8'hC7, 1'b0);
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
        check("age_p1_unit", 64'(grant_unit[3:2]), 64'(2));
        check("age_p2_unit", 64'(grant_unit[5:4]), 64'(3));
        check("age_p0_waits", 64'(grant[0]), 64'(0));
`else
        check("rr_p0_unit", 64'(grant_unit[1:0]), 64'(2));
        check("rr_p1_unit", 64'(grant_unit[3:2]), 64'(3));
        check("rr_p2_waits", 64'(grant[2]), 64'(0));
`endif
        step(1'b0, 8'hC7, 1'b0);
        step(1'b0, 8'hC7, 1'b0);

        step(1'b0, 8'hC5, 1'b0);
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
        check("release_unit2_free", 64'(unit_busy[2]), 64'(0));
        check("no_bypass_p0", 64'(grant[0]), 64'(0));
`endif
        step(1'b0, 8'hC5, 1'b0);
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
        check("regrant_p0", 64'(grant[0]), 64'(1));
        check("regrant_p0_unit", 64'(grant_unit[1:0]), 64'(2));
`endif

        step(1'b0, 8'hC5, 1'b1);
        check("flush_busy", 64'(unit_busy), 64'(0));
        step(1'b0, 8'hC5, 1'b0);
        check("after_flush_busy", 64'(unit_busy), 64'(4'hF));

        // Wrap-around age with a single free unit.
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'hE0, 1'b0);
        set_id(0, 16'hFFFE);
        set_id(1, 16'h0001);
        step(1'b0, 8'hE3, 1'b0);
        check("wrap_grant", 64'(grant[1:0]), 64'(2'b01));
        check("wrap_unit", 64'(grant_unit[1:0]), 64'(3));
        set_id(0, 16'h0000);
        step(1'b0, 8'hE3, 1'b0);

        step(1'b1, 8'hFF, 1'b1);
        check("midrun_reset_stall", 64'(stall_count), 64'(0));

        // One free unit, ports 0-3 each drop req for the cycle after being granted.
        set_id(0, 16'd3);
        set_id(1, 16'd2);
        set_id(2, 16'd1);
        set_id(3, 16'd0);
        step(1'b0, 8'hE0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 8'hE0 | {4'h0, ~m_grant[3:0]}, 1'b0);
            for (int p = 0; p < 4; p++) begin
                if (grant[p] && n_order < 16) begin
                    order[n_order] = p;
                    n_order++;
                end
            end
        end
`ifdef RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN
        check("age_oldest_first", 64'(order[0]), 64'(3));
`else
        check("rr_order0", 64'(order[0]), 64'(0));
        check("rr_order1", 64'(order[1]), 64'(1));
        check("rr_order2", 64'(order[2]), 64'(2));
        check("rr_order3", 64'(order[3]), 64'(3));
        check("rr_order4", 64'(order[4]), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/resource_pool_arbiter.md
# resource_pool_arbiter

Shared-resource scheduler between the single-instruction controllers (SICs) and a pool of identical execution units (ALUs or memory banks). Each SIC raises a request tagged with its issue ID. The arbiter assigns a free unit, holds that unit locked to the requester until the request drops, and clears all locks on rollback. It sits between the SIC array and the unit pool and replaces per-pool ad-hoc locking with one sequenced, age-aware allocator.

## Interface
Parameters:
- NUM_PORTS, 8, number of requesters (SICs)
- NUM_UNITS, 8, number of pooled units
- ID_WIDTH, 16, issue-ID width; IDs wrap modulo 2^ID_WIDTH
- UNIT_W, $clog2(NUM_UNITS) (min 1), unit index width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_PORTS  per-port request/hold level
- req_id  in  NUM_PORTS×ID_WIDTH  issue ID of each requester
- flush  in  1  rollback; drops every lock
- grant  out  NUM_PORTS  port currently owns a unit
- grant_unit  out  NUM_PORTS×UNIT_W  owned unit index (valid when grant=1)
- unit_busy  out  NUM_UNITS  unit locked
- unit_owner  out  NUM_UNITS×$clog2(NUM_PORTS)  owning port (valid when busy)
- stall_count  out  32  cycles with ≥1 pending ungranted request

## Operation
- Port states: IDLE (req=0), WAIT (req=1, no grant), HOLD (granted).
- Unit states: FREE and LOCKED, with owner stored.
- Per cycle, WAIT ports are ranked by priority. Grants go to the top-k ports, where k = number of FREE units. Highest-priority port takes the lowest-index FREE unit, next port takes the next-lowest, and so on.
- Age priority: a is older than b iff MSB of (a − b) mod 2^ID_WIDTH is 1. Equal IDs tie-break by lower port index.
- HOLD persists while req=1. req_id changes during HOLD are ignored.
- Release: req=0 on a HOLD port returns it to IDLE and its unit to FREE at the next edge.
- A released unit is not grantable in the same cycle (no bypass).
- flush=1: all ports go to IDLE and all units to FREE at the next edge. Requests in the flush cycle are not arbitrated. A port still holding req=1 afterwards re-arbitrates normally.
- stall_count: +1 per cycle in which any WAIT port is left ungranted (flush cycles excluded); wraps at 2^32.
- Unit/port invariants: never two owners per unit, never two units per port.

## Timing
- All outputs are registered.
- Reset: grant=0, grant_unit=0, unit_busy=0, unit_owner=0, stall_count=0, round-robin pointer=0.
- Grant latency: req rising in cycle t with a FREE unit gives grant=1 in cycle t+1.
- Release latency: req falling in cycle t gives grant=0 and unit_busy=0 in t+1. Earliest regrant of that unit is visible in t+2.
- Flush in t: all grant/unit_busy=0 in t+1.
- Reset mid-operation overrides flush and requests. All state returns to reset values at the edge.
- Full pool: WAIT ports remain WAIT with grant=0 indefinitely; no timeout.
- Simultaneous release and new request on the same port in one cycle cannot occur (it is one level). req toggling 1→0→1 costs one IDLE cycle.

## Configuration
- RESOURCE_POOL_ARBITER_AGE_PRIORITY_EN defined: ranking by issue-ID age as above. The round-robin pointer is unused (held at 0).
- Undefined: ranking is round-robin starting from the pointer port.
  - After any cycle with ≥1 grant, the pointer advances to one past the last-granted port, mod NUM_PORTS.
  - req_id is ignored for ranking.

## Structure
- structs.svh holds:
  - the id_older(a, b) function, parameterized by ID_WIDTH;
  - the port-state enum (IDLE/WAIT/HOLD).
- One combinational sub-module, priority_picker, sits inside the arbiter. It takes the WAIT mask, the IDs (or the pointer) and the free-unit count, and emits a ranked grant mask.
- Lock state, unit assignment, flush and the counter live in the top module.

## Test plan
- Reset, then port 3 req (id 5) with all units free: cycle+1 grant[3]=1, grant_unit[3]=0, unit_busy=8'b0000_0001.
- NUM_UNITS=2, ports 0/1/2 requesting with ids 10/4/7 (age mode): grants go to ports 1→unit0 and 2→unit1; port 0 waits and stall_count increments each cycle.
- Wrap-around age: ids 0xFFFE (port 0) and 0x0001 (port 1), one unit: port 0 granted.
- Release: port 1 drops req at cycle t. unit0 is free at t+1 and granted to waiting port 0 at t+2.
- Flush with 4 units held: at the next cycle grant=0 and unit_busy=0. Ports still requesting are regranted the cycle after.
- Macro undefined, one unit, ports 0–3 requesting continuously with 1-cycle holds: grants rotate 0,1,2,3,0.
